// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler
//   One PWM output shared by N_REQ requesters. A round-robin arbiter accepts one
//   duty request at a time. The applied duty then slews toward the accepted
//   target by at most STEP per PWM period. Duty only changes on period
//   boundaries, so every PWM cycle is complete.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; grants one winner, then goes to RAMP
//   RAMP  | slewing duty_cur toward target once per PWM period
//
// Ports
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   ena       block enable; low clears timebase and aborts any ramp
//   req       per-requester request level, held until acked
//   duty_in   requester i target duty in [i*DW +: DW]
//   ack       one-cycle accept pulse per requester
//   grant_id  index of last accepted requester
//   busy      high while ramping toward target
//   duty_cur  duty currently applied
//   pwm_out   PWM output
module pwm_duty_scheduler #(
   parameter int N_REQ = 4,
   parameter int DW    = 8,
   parameter int PRESC = 16,
   parameter int STEP  = 4,
   localparam int GW   = $clog2(N_REQ),
   localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] duty_in,
   output logic [N_REQ-1:0]    ack,
   output logic [GW-1:0]       grant_id,
   output logic                busy,
   output logic [DW-1:0]       duty_cur,
   output logic                pwm_out
);

   typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

   state_t         state;
   logic [PW-1:0]  prescaler;
   logic [DW-1:0]  pcnt;
   logic [DW-1:0]  target;
   logic [GW-1:0]  rr_last;
   logic           tick;
   logic           period_end;
   logic           win_valid;
   logic [GW-1:0]  win_idx;
   logic [DW-1:0]  diff;
   logic [DW-1:0]  duty_next;

   assign tick       = (prescaler == PW'(PRESC - 1));
   assign period_end = tick && (pcnt == '1);
   assign pwm_out    = ena && (pcnt < duty_cur);

   // Search starts one past the last grant, which gives strict rotation.
   always_comb begin
      int idx;
      idx       = 0;
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(rr_last) + k) % N_REQ;
         if (!win_valid && req[idx]) begin
            win_valid = 1'b1;
            win_idx   = GW'(idx);
         end
      end
   end

   // Clamp the step to the remaining distance so the ramp never overshoots.
   always_comb begin
      diff      = (target > duty_cur) ? (target - duty_cur) : (duty_cur - target);
      duty_next = target;
      if (diff > DW'(STEP))
         duty_next = (target > duty_cur) ? (duty_cur + DW'(STEP)) : (duty_cur - DW'(STEP));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         pcnt      <= '0;
         target    <= '0;
         rr_last   <= GW'(N_REQ - 1);
         ack       <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
         duty_cur  <= '0;
      end else if (!ena) begin
         state     <= IDLE;
         prescaler <= '0;
         pcnt      <= '0;
         ack       <= '0;
         busy      <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick)
            pcnt <= pcnt + DW'(1);
         ack <= '0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  ack      <= N_REQ'(1) << win_idx;
                  target   <= duty_in[win_idx*DW +: DW];
                  grant_id <= win_idx;
                  rr_last  <= win_idx;
                  busy     <= 1'b1;
                  state    <= RAMP;
               end
            end
            RAMP: begin
               if (duty_cur == target) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (period_end) begin
                  duty_cur <= duty_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
